regfile_dump: RTL and testbench



---
 rtl/regfile_dump.sv | 160 ++++++++++++++++
 tb/tb_regfile_dump.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Sequential dumper for the regfile debug read port: walks an inclusive wrap-around register
// range and streams each value as a valid/ready beat. Define REGDUMP_CSUM_EN for a trailing XOR checksum beat.
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_i,
    input  logic [ADDR_W-1:0] last_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_reg_en_o,
    output logic [ADDR_W-1:0] rd_reg_addr_o,
    input  logic [DATA_W-1:0] rd_reg_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic              dump_last_o
);

`ifdef REGDUMP_CSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
`endif

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] rdAddr_q;
    logic [ADDR_W-1:0] dumpAddr_q;
    logic [DATA_W-1:0] dumpData_q;
    logic              rdEn_q;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic              last_q;
`ifdef REGDUMP_CSUM_EN
    logic [DATA_W-1:0] acc_q;
`endif

    logic [ADDR_W-1:0] cntInc;
    logic              lastBeat;

    // The counter width is the register index width, so the increment wraps 31 -> 0 by itself.
    assign cntInc   = cnt_q + ADDR_W'(1);
    assign lastBeat = (cnt_q == end_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            end_q      <= '0;
            rdAddr_q   <= '0;
            dumpAddr_q <= '0;
            dumpData_q <= '0;
            rdEn_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
`ifdef REGDUMP_CSUM_EN
            acc_q      <= '0;
`endif
        end else begin
            done_q   <= 1'b0;
            rdEn_q   <= 1'b0;
            rdAddr_q <= '0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cnt_q    <= first_i;
                        end_q    <= last_i;
                        rdEn_q   <= 1'b1;
                        rdAddr_q <= first_i;
                        busy_q   <= 1'b1;
                        state_q  <= READ;
`ifdef REGDUMP_CSUM_EN
                        acc_q    <= '0;
`endif
                    end
                end
                READ: begin
                    dumpData_q <= rd_reg_data_i;
                    dumpAddr_q <= cnt_q;
                    valid_q    <= 1'b1;
                    state_q    <= SEND;
`ifdef REGDUMP_CSUM_EN
                    acc_q      <= acc_q ^ rd_reg_data_i;
                    last_q     <= 1'b0;
`else
                    last_q     <= lastBeat;
`endif
                end
                SEND: begin
                    if (dump_ready_i) begin
                        if (!lastBeat) begin
                            valid_q  <= 1'b0;
                            cnt_q    <= cntInc;
                            rdEn_q   <= 1'b1;
                            rdAddr_q <= cntInc;
                            state_q  <= READ;
                        end else begin
`ifdef REGDUMP_CSUM_EN
                            // Checksum beat follows immediately, so valid stays high.
                            dumpData_q <= acc_q;
                            dumpAddr_q <= '0;
                            last_q     <= 1'b1;
                            state_q    <= CSUM;
`else
                            valid_q    <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
`endif
                        end
                    end
                end
`ifdef REGDUMP_CSUM_EN
                CSUM: begin
                    if (dump_ready_i) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            // Abort wins over everything, including a handshake in the same cycle.
            if (abort_i && (state_q != IDLE)) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                valid_q  <= 1'b0;
                done_q   <= 1'b0;
                rdEn_q   <= 1'b0;
                rdAddr_q <= '0;
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign rd_reg_en_o   = rdEn_q;
    assign rd_reg_addr_o = rdAddr_q;
    assign dump_valid_o  = valid_q;
    assign dump_data_o   = dumpData_q;
    assign dump_addr_o   = dumpAddr_q;
    assign dump_last_o   = last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a beat-queue reference model checked every cycle,
// plus directed scenarios with hand-computed beat timing and payloads.
module tb_regfile_dump;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
        bit          csum;
    } beat_t;

    typedef struct {
        int          rel;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } hs_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, ready;
    logic [4:0]  first, last;
    logic        busy, done, rdEn, valid, dLast;
    logic [4:0]  rdAddr, dAddr;
    logic [31:0] rdData, dData;
    logic [31:0] regs [32];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sCyc = 0;

    // Reference model state: remaining beats plus what the next cycle must show.
    beat_t mQ[$];
    bit    mActive = 0, mExpRead = 0, mExpValid = 0, mExpDone = 0;
    bit    modelOn = 0, rstPrev = 0;
    hs_t   hsLog[$];
    int    doneLog[$];

    regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .first_i(first), .last_i(last),
        .abort_i(abort), .busy_o(busy), .done_o(done), .rd_reg_en_o(rdEn),
        .rd_reg_addr_o(rdAddr), .rd_reg_data_i(rdData), .dump_valid_o(valid),
        .dump_ready_i(ready), .dump_data_o(dData), .dump_addr_o(dAddr), .dump_last_o(dLast)
    );

    always #5 clk = ~clk;

    assign rdData = (rdAddr == 5'd0) ? 32'h0 : regs[rdAddr];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model mid-cycle, then advance the model on this cycle's inputs.
    always @(negedge clk) begin
        bit nR, nV, nD;
        int n;
        logic [31:0] d;
        logic [31:0] acc;
        logic [4:0]  a;
        logic        lf;
        if (modelOn) begin
            if (rstPrev) begin
                checkOutput("rst_data", dData, 32'h0);
                checkOutput("rst_addr", 32'(dAddr), 32'h0);
                checkOutput("rst_last", 32'(dLast), 32'h0);
            end
            checkOutput("rd_en", 32'(rdEn), 32'(mExpRead));
            checkOutput("rd_addr", 32'(rdAddr), mExpRead ? 32'(mQ[0].addr) : 32'h0);
            checkOutput("valid", 32'(valid), 32'(mExpValid));
            if (mExpValid) begin
                checkOutput("beat_data", dData, mQ[0].data);
                checkOutput("beat_addr", 32'(dAddr), 32'(mQ[0].addr));
                checkOutput("beat_last", 32'(dLast), 32'(mQ[0].last));
            end
            checkOutput("done", 32'(done), 32'(mExpDone));
            checkOutput("busy", 32'(busy), 32'(mActive || mExpDone));
        end
        if (valid && ready && !abort && !rst)
            hsLog.push_back('{rel: cyc - sCyc, addr: dAddr, data: dData, last: dLast});
        if (done) doneLog.push_back(cyc - sCyc);

        if (rst) begin
            mActive = 0; mExpRead = 0; mExpValid = 0; mExpDone = 0;
            mQ.delete();
        end else begin
            nR = 0; nV = 0; nD = 0;
            if (mActive) begin
                if (abort) begin
                    mActive = 0;
                    mQ.delete();
                end else if (mExpRead) begin
                    nV = 1;
                end else if (mExpValid) begin
                    if (ready) begin
                        void'(mQ.pop_front());
                        if (mQ.size() == 0) begin
                            mActive = 0;
                            nD = 1;
                        end else if (mQ[0].csum) nV = 1;
                        else nR = 1;
                    end else nV = 1;
                end
            end else if (!mExpDone && start) begin
                n = int'(5'(last - first)) + 1;
                acc = 32'h0;
                for (int i = 0; i < n; i++) begin
                    a = 5'(first + 5'(i));
                    d = (a == 5'd0) ? 32'h0 : regs[a];
                    acc = acc ^ d;
`ifdef REGDUMP_CSUM_EN
                    lf = 1'b0;
`else
                    lf = (i == n - 1);
`endif
                    mQ.push_back('{addr: a, data: d, last: lf, csum: 0});
                end
`ifdef REGDUMP_CSUM_EN
                mQ.push_back('{addr: 5'd0, data: acc, last: 1'b1, csum: 1});
`endif
                mActive = 1;
                nR = 1;
                sCyc = cyc;
            end
            mExpRead = nR; mExpValid = nV; mExpDone = nD;
        end
        rstPrev = rst;
        if (rst) modelOn = 1;
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // One dump: start in cycle 0, then drive ready/abort/reset/stray-start by cycle number.
    task automatic applyStimulus(input logic [4:0] f, input logic [4:0] l, input bit randReady,
                                 input int lowFrom, input int lowTo, input int abortAt,
                                 input int rstAt, input int busyStartAt);
        int rel;
        hsLog.delete();
        doneLog.delete();
        nextCycle();
        start = 1; first = f; last = l; abort = 0; rst = 0;
        ready = randReady ? ($urandom_range(0, 9) < 7) : 1'b1;
        rel = 0;
        forever begin
            nextCycle();
            rel++;
            if (!(mActive || mExpDone)) break;
            if (rel > 600) begin
                checkOutput("dump_timeout", 32'(rel), 32'd600);
                break;
            end
            start = (rel == busyStartAt);
            if (start) begin
                first = 5'($urandom);
                last  = 5'($urandom);
            end
            ready = randReady ? ($urandom_range(0, 9) < 7) : !(rel >= lowFrom && rel <= lowTo);
            abort = (rel == abortAt);
            rst   = (rel == rstAt);
        end
        start = 0; abort = 0; rst = 0; ready = 1;
    endtask

    task automatic checkBeat(input int idx, input int rel, input logic [4:0] a,
                             input logic [31:0] d, input logic l);
        if (idx < hsLog.size()) begin
            checkOutput($sformatf("beat%0d_rel", idx), 32'(hsLog[idx].rel), 32'(rel));
            checkOutput($sformatf("beat%0d_addr", idx), 32'(hsLog[idx].addr), 32'(a));
            checkOutput($sformatf("beat%0d_data", idx), hsLog[idx].data, d);
            checkOutput($sformatf("beat%0d_last", idx), 32'(hsLog[idx].last), 32'(l));
        end else begin
            checkOutput($sformatf("beat%0d_present", idx), 32'(hsLog.size()), 32'(idx + 1));
        end
    endtask

    task automatic checkDone(input int rel);
        if (doneLog.size() > 0) checkOutput("done_rel", 32'(doneLog[0]), 32'(rel));
        else checkOutput("done_present", 32'(doneLog.size()), 32'd1);
    endtask

    task automatic checkIdleZero();
        checkOutput("zero_busy", 32'(busy), 32'h0);
        checkOutput("zero_done", 32'(done), 32'h0);
        checkOutput("zero_rd_en", 32'(rdEn), 32'h0);
        checkOutput("zero_rd_addr", 32'(rdAddr), 32'h0);
        checkOutput("zero_valid", 32'(valid), 32'h0);
        checkOutput("zero_data", dData, 32'h0);
        checkOutput("zero_addr", 32'(dAddr), 32'h0);
        checkOutput("zero_last", 32'(dLast), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1; start = 0; abort = 0; ready = 1; first = 0; last = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11;
        repeat (3) nextCycle();
        rst = 0;
        #1;
        checkIdleZero();

        $display("[TB] basic range 1..3");
        applyStimulus(5'd1, 5'd3, 0, 0, -1, 0, 0, 0);
`ifdef REGDUMP_CSUM_EN
        checkBeat(0, 2, 5'd1, 32'h11, 1'b0);
        checkBeat(1, 4, 5'd2, 32'h22, 1'b0);
        checkBeat(2, 6, 5'd3, 32'h33, 1'b0);
        checkBeat(3, 7, 5'd0, 32'h00, 1'b1);
        checkDone(8);
`else
        checkBeat(0, 2, 5'd1, 32'h11, 1'b0);
        checkBeat(1, 4, 5'd2, 32'h22, 1'b0);
        checkBeat(2, 6, 5'd3, 32'h33, 1'b1);
        checkDone(7);
`endif

        $display("[TB] wrap range 30..1");
        applyStimulus(5'd30, 5'd1, 0, 0, -1, 0, 0, 0);
        checkBeat(0, 2, 5'd30, 32'h1FE, 1'b0);
        checkBeat(1, 4, 5'd31, 32'h20F, 1'b0);
        checkBeat(2, 6, 5'd0, 32'h0, 1'b0);
`ifdef REGDUMP_CSUM_EN
        checkBeat(3, 8, 5'd1, 32'h11, 1'b0);
`else
        checkBeat(3, 8, 5'd1, 32'h11, 1'b1);
`endif

        $display("[TB] stall on beat 2");
        applyStimulus(5'd1, 5'd3, 0, 4, 8, 0, 0, 0);
        checkBeat(1, 9, 5'd2, 32'h22, 1'b0);
`ifdef REGDUMP_CSUM_EN
        checkBeat(2, 11, 5'd3, 32'h33, 1'b0);
        checkDone(13);
`else
        checkBeat(2, 11, 5'd3, 32'h33, 1'b1);
        checkDone(12);
`endif

        $display("[TB] abort during beat 2 of 4");
        applyStimulus(5'd10, 5'd13, 0, 0, -1, 4, 0, 0);
        checkOutput("abort_beats", 32'(hsLog.size()), 32'd1);
        checkOutput("abort_no_done", 32'(doneLog.size()), 32'd0);
        applyStimulus(5'd7, 5'd7, 0, 0, -1, 0, 0, 0);
`ifdef REGDUMP_CSUM_EN
        checkBeat(0, 2, 5'd7, 32'h77, 1'b0);
        checkBeat(1, 3, 5'd0, 32'h77, 1'b1);
        checkDone(4);
`else
        checkBeat(0, 2, 5'd7, 32'h77, 1'b1);
        checkDone(3);
`endif

        $display("[TB] single register 5");
        regs[5] = 32'hDEADBEEF;
        applyStimulus(5'd5, 5'd5, 0, 0, -1, 0, 0, 0);
`ifdef REGDUMP_CSUM_EN
        checkOutput("single_beats", 32'(hsLog.size()), 32'd2);
        checkBeat(0, 2, 5'd5, 32'hDEADBEEF, 1'b0);
        checkBeat(1, 3, 5'd0, 32'hDEADBEEF, 1'b1);
`else
        checkOutput("single_beats", 32'(hsLog.size()), 32'd1);
        checkBeat(0, 2, 5'd5, 32'hDEADBEEF, 1'b1);
`endif

        $display("[TB] reset mid-dump with stray start");
        applyStimulus(5'd0, 5'd31, 0, 0, -1, 0, 5, 3);
        #1;
        checkIdleZero();
        checkBeat(1, 4, 5'd1, 32'h11, 1'b0);

        $display("[TB] randomized dumps");
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            applyStimulus(5'($urandom), 5'($urandom), 1, 0, -1,
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0,
                          0, int'($urandom_range(1, 20)));
        end
        nextCycle();
        nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
